// File: rtl/keys_pkg.sv
// keys_pkg: shared key-scanner sizing, event record layout and scan-index helper
package keys_pkg;
    localparam int KEYS = 61;
    localparam int IDX_W = $clog2(KEYS);
    localparam int FIFO_DEPTH = 8;
    typedef struct packed {
        logic [IDX_W-1:0] code;
        logic level;
    } evt_t;
    function automatic int next_idx(input int i, input int n);
        return (i == n - 1) ? 0 : i + 1;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; full is judged before any pop, so no push-through
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full_o = count_o == CNT_W'(DEPTH);
    assign empty_o = count_o == '0;
    assign do_push = push_i && !full_o;
    assign do_pop = pop_i && !empty_o;
    assign data_o = mem[rd_ptr];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count_o <= count_o + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/key_event_encoder.sv
// key_event_encoder: round-robin scan of debounced key levels, queuing one {code, level} event per reported change
module key_event_encoder #(
    parameter int KEYS = keys_pkg::KEYS,
    parameter int FIFO_DEPTH = keys_pkg::FIFO_DEPTH,
    localparam int IDX_W = $clog2(KEYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEYS-1:0]  keys_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDX_W-1:0] evt_code_o,
    output logic             evt_level_o,
    output logic             pending_o
);
    import keys_pkg::*;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    logic [KEYS-1:0] rep;
    logic [IDX_W-1:0] idx;
    logic key, differ, full, empty, push, advance;
    logic [CNT_W-1:0] fifo_count;
    logic [IDX_W:0] head;
    assign key = keys_i[idx];
    assign differ = key != rep[idx];
    // a change seen while the queue is full parks the scan on that key until space frees up
    assign push = differ && !full;
    assign advance = !differ || !full;
    assign pending_o = |(keys_i ^ rep);
    assign evt_valid_o = !empty;
    assign evt_code_o = head[IDX_W:1];
    assign evt_level_o = head[0];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rep <= '1;
            idx <= '0;
        end else begin
            if (push) rep[idx] <= key;
            if (advance) idx <= IDX_W'(next_idx(int'(idx), KEYS));
        end
    end
    sync_fifo #(
        .WIDTH(IDX_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push),
        .pop_i  (evt_valid_o && evt_ready_i),
        .data_i ({idx, key}),
        .data_o (head),
        .full_o (full),
        .empty_o(empty),
        .count_o(fifo_count)
    );
    assert property (@(posedge clk_i) disable iff (rst_i) evt_valid_o == (fifo_count != '0));
endmodule
